anton_neopixel_feeder: RTL and testbench

- Upstream stage of the neopixel module. Accepts a valid/ready stream of pixel words and serialises each one into byte writes on the neopixel module's register/pixel bus.
- At end of frame it writes the pixel-count limit register, then pulses syncStart so the stream logic renders the frame.
- Frames start only while the neopixel output is idle, so a frame being streamed is never overwritten.

---
 rtl/anton_neopixel_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_anton_neopixel_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_feeder.sv
// -----------------------------------------------------------------------------
// anton_neopixel_feeder
//
// Upstream stage of the neopixel module. Takes a valid/ready stream of pixel
// words and turns each one into byte writes on the neopixel register/pixel bus.
// At end of frame it writes the pixel-count limit (reg_max), then pulses
// syncStart so the stream logic renders the frame. A frame only starts while
// the neopixel output is idle, so a frame being streamed is never overwritten.
//
// Handshake: a pixel moves when pixValid && pixReady on a rising busClk edge.
// pixReady is registered, high only in ACCEPT, and does not depend on pixValid.
// The feeder never stalls the bus side: every busWrite is a single-cycle
// strobe with busAddr/busData valid in the same cycle.
//
// Ports:
//   busClk, busReset   clock and synchronous active-high reset
//   pixValid/pixReady  input pixel handshake
//   pixData            {W,R,G,B}, W in bits 31:24
//   pixLast            marks the last pixel of a frame
//   mode32             1 = GRBW (4 bytes/pixel), 0 = GRB (3 bytes/pixel)
//   neoState           neopixel stream busy (outputting or syncing)
//   busAddr/busData    bus write address and data
//   busWrite           one-cycle write strobe
//   syncStart          one-cycle frame-commit pulse
//   frameDone          one-cycle pulse, coincident with syncStart
//   overflow           sticky: pixels dropped in the current or last frame
//   busy               high in every state except WAIT_IDLE
//   dbgState           current FSM state, for observation only
// -----------------------------------------------------------------------------
module anton_neopixel_feeder #(
    parameter int          BUFFER_END  = 8191,
    parameter logic [13:0] MAX_ADDR_LO = 14'h2000,
    parameter logic [13:0] MAX_ADDR_HI = 14'h2001
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic        pixValid,
    output logic        pixReady,
    input  logic [31:0] pixData,
    input  logic        pixLast,
    input  logic        mode32,
    input  logic        neoState,
    output logic [13:0] busAddr,
    output logic [7:0]  busData,
    output logic        busWrite,
    output logic        syncStart,
    output logic        frameDone,
    output logic        overflow,
    output logic        busy,
    output logic [2:0]  dbgState
);

    // One spare bit so the pointer can sit one past BUFFER_END without wrapping.
    localparam int PW = $clog2(BUFFER_END + 1) + 1;
    localparam logic [PW:0] END_V = (PW + 1)'(BUFFER_END);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_ACCEPT    = 3'd1,
        S_WRITE     = 3'd2,
        S_MAX_LO    = 3'd3,
        S_MAX_HI    = 3'd4,
        S_SYNC      = 3'd5
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [12:0]   r_cnt;
    logic          r_mode;
    logic [31:0]   r_data;
    logic          r_last;
    logic [2:0]    r_idx;     // bytes of the current pixel already issued
    logic          r_skip;    // ignore neoState for one cycle after SYNC
    logic          r_pixReady;
    logic [13:0]   r_busAddr;
    logic [7:0]    r_busData;
    logic          r_busWrite;
    logic          r_syncStart;
    logic          r_frameDone;
    logic          r_overflow;
    logic          r_busy;

    logic [2:0]    w_bpp;
    logic [PW:0]   w_last_byte;
    logic          w_fits;
    logic          w_transfer;
    logic [12:0]   w_cnt_inc;
    logic [12:0]   w_max_cur;

    // reg_max holds count-1; a frame with no written pixels reports 0.
    function automatic logic [12:0] max_val(input logic [12:0] c);
        logic [12:0] v;
        v = (c == 13'd0) ? 13'd0 : c - 13'd1;
        return v;
    endfunction

    // Bus byte order is G, R, B, W.
    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] i);
        logic [7:0] v;
        case (i)
            2'd0:    v = d[15:8];
            2'd1:    v = d[23:16];
            2'd2:    v = d[7:0];
            default: v = d[31:24];
        endcase
        return v;
    endfunction

    assign w_bpp       = r_mode ? 3'd4 : 3'd3;
    assign w_last_byte = {1'b0, r_ptr} + (PW + 1)'(w_bpp) - (PW + 1)'(1);
    assign w_fits      = (w_last_byte <= END_V);
    assign w_transfer  = pixValid && r_pixReady;
    assign w_cnt_inc   = r_cnt + 13'd1;
    assign w_max_cur   = max_val(r_cnt);

    always_ff @(posedge busClk) begin
        if (busReset) begin
            r_state     <= S_WAIT_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_idx       <= '0;
            r_skip      <= 1'b0;
            r_pixReady  <= 1'b0;
            r_busAddr   <= '0;
            r_busData   <= '0;
            r_busWrite  <= 1'b0;
            r_syncStart <= 1'b0;
            r_frameDone <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busWrite  <= 1'b0;
            r_syncStart <= 1'b0;
            r_frameDone <= 1'b0;
            case (r_state)
                S_WAIT_IDLE: begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (!neoState) begin
                        r_mode     <= mode32;
                        r_ptr      <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pixReady <= 1'b1;
                        r_state    <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_transfer) begin
                        r_data <= pixData;
                        r_last <= pixLast;
                        if (w_fits) begin
                            // First byte (G) goes out while the pixel is latched.
                            r_busWrite <= 1'b1;
                            r_busAddr  <= 14'(r_ptr);
                            r_busData  <= pixData[15:8];
                            r_ptr      <= r_ptr + 1'b1;
                            r_idx      <= 3'd1;
                            r_pixReady <= 1'b0;
                            r_state    <= S_WRITE;
                        end else begin
                            // Pixel does not fit completely: drop it whole.
                            r_overflow <= 1'b1;
                            if (pixLast) begin
                                r_pixReady <= 1'b0;
                                r_busWrite <= 1'b1;
                                r_busAddr  <= MAX_ADDR_LO;
                                r_busData  <= w_max_cur[7:0];
                                r_state    <= S_MAX_LO;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (r_idx == w_bpp) begin
                        // Final byte is on the bus this cycle.
                        r_cnt <= w_cnt_inc;
                        if (r_last) begin
                            // (cnt+1)-1 == cnt, so the old count is reg_max.
                            r_busWrite <= 1'b1;
                            r_busAddr  <= MAX_ADDR_LO;
                            r_busData  <= r_cnt[7:0];
                            r_state    <= S_MAX_LO;
                        end else begin
                            r_pixReady <= 1'b1;
                            r_state    <= S_ACCEPT;
                        end
                    end else begin
                        r_busWrite <= 1'b1;
                        r_busAddr  <= 14'(r_ptr);
                        r_busData  <= byte_sel(r_data, r_idx[1:0]);
                        r_ptr      <= r_ptr + 1'b1;
                        r_idx      <= r_idx + 3'd1;
                    end
                end
                S_MAX_LO: begin
                    r_busWrite <= 1'b1;
                    r_busAddr  <= MAX_ADDR_HI;
                    r_busData  <= {3'b000, w_max_cur[12:8]};
                    r_state    <= S_MAX_HI;
                end
                S_MAX_HI: begin
                    r_syncStart <= 1'b1;
                    r_frameDone <= 1'b1;
                    r_state     <= S_SYNC;
                end
                S_SYNC: begin
                    r_busy  <= 1'b0;
                    r_skip  <= 1'b1;
                    r_state <= S_WAIT_IDLE;
                end
                default: begin
                    r_state <= S_WAIT_IDLE;
                end
            endcase
        end
    end

    assign pixReady  = r_pixReady;
    assign busAddr   = r_busAddr;
    assign busData   = r_busData;
    assign busWrite  = r_busWrite;
    assign syncStart = r_syncStart;
    assign frameDone = r_frameDone;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_anton_neopixel_feeder.sv
// -----------------------------------------------------------------------------
// Bench for anton_neopixel_feeder. Two instances: index 0 with the full
// 8 KiB buffer, index 1 with BUFFER_END = 8 to reach the overflow boundary.
// Expected bus traffic is produced by a frame-level model (byte list per pixel,
// count-derived reg_max) and consumed by a negedge monitor.
// Queue entry: {is_sync, addr[13:0], data[7:0]}.
// -----------------------------------------------------------------------------
module tb_anton_neopixel_feeder;

    localparam int END0 = 8191;
    localparam int END1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        bus_reset [2];
    logic        pix_valid [2];
    logic [31:0] pix_data  [2];
    logic        pix_last  [2];
    logic        mode32    [2];
    logic        neo_state [2];
    logic        pix_ready [2];
    logic [13:0] bus_addr  [2];
    logic [7:0]  bus_data  [2];
    logic        bus_write [2];
    logic        sync_start[2];
    logic        frame_done[2];
    logic        overflow  [2];
    logic        busy      [2];
    logic [2:0]  dbg_state [2];

    anton_neopixel_feeder #(.BUFFER_END(END0)) u_big (
        .busClk(clk), .busReset(bus_reset[0]),
        .pixValid(pix_valid[0]), .pixReady(pix_ready[0]),
        .pixData(pix_data[0]), .pixLast(pix_last[0]),
        .mode32(mode32[0]), .neoState(neo_state[0]),
        .busAddr(bus_addr[0]), .busData(bus_data[0]), .busWrite(bus_write[0]),
        .syncStart(sync_start[0]), .frameDone(frame_done[0]),
        .overflow(overflow[0]), .busy(busy[0]), .dbgState(dbg_state[0])
    );

    anton_neopixel_feeder #(.BUFFER_END(END1)) u_small (
        .busClk(clk), .busReset(bus_reset[1]),
        .pixValid(pix_valid[1]), .pixReady(pix_ready[1]),
        .pixData(pix_data[1]), .pixLast(pix_last[1]),
        .mode32(mode32[1]), .neoState(neo_state[1]),
        .busAddr(bus_addr[1]), .busData(bus_data[1]), .busWrite(bus_write[1]),
        .syncStart(sync_start[1]), .frameDone(frame_done[1]),
        .overflow(overflow[1]), .busy(busy[1]), .dbgState(dbg_state[1])
    );

    // ---------------- scoreboard state ----------------
    logic [22:0] exp_q0[$];
    logic [22:0] exp_q1[$];
    logic [31:0] frame_px[$];
    int tests = 0;
    int fails = 0;
    int sync_cnt[2] = '{0, 0};
    int m_ptr[2];
    int m_cnt[2];
    bit m_mode[2];
    bit m_ovf[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int k, input logic [22:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    // Frame-level reference: a pixel is written whole at the next free
    // addresses if its last byte is within the buffer, otherwise dropped.
    task automatic model_pixel(input int k, input logic [31:0] d, input bit last, output bit fits);
        int bpp;
        int endv;
        int mx;
        logic [7:0] b[4];
        bpp  = m_mode[k] ? 4 : 3;
        endv = (k == 0) ? END0 : END1;
        b[0] = d[15:8];
        b[1] = d[23:16];
        b[2] = d[7:0];
        b[3] = d[31:24];
        fits = (m_ptr[k] + bpp - 1 <= endv);
        if (fits) begin
            for (int i = 0; i < bpp; i++) begin
                push_exp(k, {1'b0, 14'(m_ptr[k]), b[i]});
                m_ptr[k]++;
            end
            m_cnt[k]++;
        end else begin
            m_ovf[k] = 1'b1;
        end
        if (last) begin
            mx = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
            push_exp(k, {1'b0, 14'h2000, 8'(mx)});
            push_exp(k, {1'b0, 14'h2001, 8'((mx >> 8) & 31)});
            push_exp(k, {1'b1, 14'h0000, 8'h00});
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int k);
        logic [22:0] e;
        bit have;
        if (bus_write[k] || sync_start[k]) begin
            have = 1'b0;
            e    = '0;
            if (k == 0 && exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                have = 1'b1;
            end else if (k == 1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                have = 1'b1;
            end
            if (!have)
                check("unexpected_output", {30'd0, bus_write[k], sync_start[k]}, 32'd0);
            else if (e[22])
                check("sync_slot", {29'd0, bus_write[k], sync_start[k], frame_done[k]}, 32'd3);
            else
                check("bus_write", {8'd0, bus_write[k], sync_start[k], bus_addr[k], bus_data[k]},
                      {8'd0, 2'b10, e[21:0]});
            if (sync_start[k]) sync_cnt[k]++;
        end else if (frame_done[k]) begin
            check("stray_frame_done", {31'd0, frame_done[k]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- drivers ----------------
    task automatic start_frame(input int k, input bit mode);
        mode32[k]    = mode;
        m_mode[k]    = mode;
        m_ptr[k]     = 0;
        m_cnt[k]     = 0;
        m_ovf[k]     = 1'b0;
        neo_state[k] = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the transfer (plus the
    // write window when chk_gap is set).
    task automatic send_pixel(input int k, input logic [31:0] d, input bit last, input bit chk_gap);
        bit fits;
        int budget;
        int bpp;
        pix_valid[k] = 1'b1;
        pix_data[k]  = d;
        pix_last[k]  = last;
        budget = 0;
        while (!pix_ready[k] && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!pix_ready[k]) begin
            check("ready_timeout", {31'd0, pix_ready[k]}, 32'd1);
            pix_valid[k] = 1'b0;
            return;
        end
        model_pixel(k, d, last, fits);
        @(negedge clk);
        pix_valid[k] = 1'b0;
        pix_last[k]  = 1'b0;
        if (chk_gap && fits) begin
            bpp = m_mode[k] ? 4 : 3;
            for (int i = 0; i < bpp; i++) begin
                check("ready_low_in_write", {31'd0, pix_ready[k]}, 32'd0);
                @(negedge clk);
            end
            if (!last) check("ready_after_write", {31'd0, pix_ready[k]}, 32'd1);
        end
    endtask

    task automatic run_frame(input int k, input bit mode, input bit rnd, input bit chk_gap);
        int s0;
        int budget;
        int n;
        n = frame_px.size();
        start_frame(k, mode);
        budget = 0;
        while (!pix_ready[k] && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("ready_at_start", {31'd0, pix_ready[k]}, 32'd1);
        check("ovf_clear_at_start", {31'd0, overflow[k]}, 32'd0);
        s0 = sync_cnt[k];
        for (int i = 0; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_pixel(k, frame_px[i], i == n - 1, chk_gap);
            if (rnd) mode32[k] = 1'($urandom_range(0, 1));
        end
        neo_state[k] = 1'b1;
        budget = 0;
        while (sync_cnt[k] == s0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check("sync_pulses", sync_cnt[k] - s0, 32'd1);
        check("ovf_sticky", {31'd0, overflow[k]}, {31'd0, m_ovf[k]});
        check("busy_low_idle", {31'd0, busy[k]}, 32'd0);
        check("queue_drained", (k == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
    endtask

    task automatic rand_frame(input int n);
        frame_px.delete();
        for (int i = 0; i < n; i++) frame_px.push_back($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        int w;
        int s0;
        for (int k = 0; k < 2; k++) begin
            bus_reset[k] = 1'b1;
            pix_valid[k] = 1'b0;
            pix_data[k]  = '0;
            pix_last[k]  = 1'b0;
            mode32[k]    = 1'b0;
            neo_state[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        // Reset values
        check("rst_pixReady",  {31'd0, pix_ready[0]},  32'd0);
        check("rst_busAddr",   {18'd0, bus_addr[0]},   32'd0);
        check("rst_busData",   {24'd0, bus_data[0]},   32'd0);
        check("rst_busWrite",  {31'd0, bus_write[0]},  32'd0);
        check("rst_syncStart", {31'd0, sync_start[0]}, 32'd0);
        check("rst_frameDone", {31'd0, frame_done[0]}, 32'd0);
        check("rst_overflow",  {31'd0, overflow[0]},   32'd0);
        check("rst_busy",      {31'd0, busy[0]},       32'd0);
        bus_reset[0] = 1'b0;
        bus_reset[1] = 1'b0;

        // neoState held busy: nothing may start
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pix_ready[0] || bus_write[0] || busy[0]) bad++;
        end
        check("idle_hold_quiet", bad, 32'd0);
        mode32[0]    = 1'b0;
        neo_state[0] = 1'b0;
        w = 0;
        while (!pix_ready[0] && w < 2) begin
            @(negedge clk);
            w++;
        end
        check("ready_after_idle", {31'd0, pix_ready[0]}, 32'd1);

        // 24-bit two-pixel frame
        frame_px.delete();
        frame_px.push_back(32'h00112233);
        frame_px.push_back(32'h00445566);
        run_frame(0, 1'b0, 1'b0, 1'b1);

        // 32-bit single pixel
        frame_px.delete();
        frame_px.push_back(32'hAABBCCDD);
        run_frame(0, 1'b1, 1'b0, 1'b1);

        // Small buffer: 4 pixels of 24-bit, last one dropped
        rand_frame(4);
        run_frame(1, 1'b0, 1'b0, 1'b1);
        // 32-bit: third pixel would straddle the end, dropped whole
        rand_frame(3);
        run_frame(1, 1'b1, 1'b0, 1'b1);
        // Dropped non-last then dropped last
        rand_frame(5);
        run_frame(1, 1'b0, 1'b1, 1'b1);
        // Fits completely: overflow must be clear at end
        rand_frame(2);
        run_frame(1, 1'b0, 1'b0, 1'b1);

        // Reset during the WRITE of the second pixel
        start_frame(0, 1'b0);
        send_pixel(0, $urandom, 1'b0, 1'b0);
        send_pixel(0, $urandom, 1'b0, 1'b0);
        bus_reset[0] = 1'b1;
        neo_state[0] = 1'b1;
        @(negedge clk);
        check("mid_rst_pixReady",  {31'd0, pix_ready[0]},  32'd0);
        check("mid_rst_busAddr",   {18'd0, bus_addr[0]},   32'd0);
        check("mid_rst_busData",   {24'd0, bus_data[0]},   32'd0);
        check("mid_rst_busWrite",  {31'd0, bus_write[0]},  32'd0);
        check("mid_rst_syncStart", {31'd0, sync_start[0]}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy[0]},       32'd0);
        exp_q0.delete();
        bus_reset[0] = 1'b0;
        s0 = sync_cnt[0];
        repeat (20) @(negedge clk);
        check("no_sync_after_rst", sync_cnt[0] - s0, 32'd0);
        rand_frame(3);
        run_frame(0, 1'b0, 1'b0, 1'b1);

        // Random stream: 1000 pixels, 24-bit, last every 50
        s0 = sync_cnt[0];
        for (int f = 0; f < 20; f++) begin
            rand_frame(50);
            run_frame(0, 1'b0, 1'b1, 1'b1);
        end
        check("random_sync_total", sync_cnt[0] - s0, 32'd20);

        repeat (5) @(negedge clk);
        check("final_q0_empty", exp_q0.size(), 32'd0);
        check("final_q1_empty", exp_q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
